// File: rtl/mux_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_pkg
//   Shared types, constants and the round-robin search helper for the
//   4-to-1 mux arbiter (mux_4x1_rr_arbiter) and its datapath (mux_4x1).
//
//   N_REQ   : number of requesters sharing the mux
//   SEL_W   : width of the mux select / requester index
//   state_t : arbiter state (IDLE = no owner, BUSY = grant held)
//   pick_t  : result of rr_pick (found flag + winning index)
//   rr_pick : first requester with req high, searching from ptr upward,
//             wrapping modulo N_REQ
// -----------------------------------------------------------------------------
package mux_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [SEL_W-1:0] ptr);
        pick_t            p;
        logic [SEL_W-1:0] idx;
        p = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            // SEL_W-bit addition wraps naturally, giving the mod-4 search order
            idx = ptr + i[SEL_W-1:0];
            if (!p.found && req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux_4x1.sv
// -----------------------------------------------------------------------------
// mux_4x1
//   Purely combinational W-bit 4-to-1 multiplexer.
//
//   sel     in  SEL_W  input select
//   d0..d3  in  W      data inputs
//   y       out W      selected data
// -----------------------------------------------------------------------------
module mux_4x1
    import mux_arb_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    output logic [W-1:0]     y
);

    always_comb begin
        y = '0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/mux_4x1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_4x1_rr_arbiter
//   Round-robin arbiter sharing one W-bit 4-to-1 mux among four requesters.
//   A grant is held until the owner asserts done, drops req, or has held it
//   for HOLD_MAX cycles (HOLD_MAX = 0 disables the timeout). On release the
//   same edge re-arbitrates with the releasing owner at lowest priority.
//
//   clk          in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high reset
//   req          in   4   level-sensitive request per requester
//   done         in   4   release strobe; only done[owner] is honoured
//   d0..d3       in   W   mux data inputs, one per requester
//   gnt          out  4   registered one-hot grant
//   sel          out  2   registered mux select (index of gnt bit)
//   y            out  W   muxed data, combinational from sel
//   y_valid      out  1   high while a grant is held
//   grant_count  out  16  saturating count of issued grants
//                         (present only when MUX_ARB_STATS_EN is defined)
// -----------------------------------------------------------------------------
module mux_4x1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic [W-1:0]     y,
    output logic             y_valid
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [15:0]      grant_count
`endif
);

    localparam int unsigned HC_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    state_t            state_q,    state_d;
    logic [N_REQ-1:0]  gnt_q,      gnt_d;
    logic [SEL_W-1:0]  sel_q,      sel_d;
    logic [SEL_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic              new_grant;
    logic              release_own;
    logic              timeout;
    logic [SEL_W-1:0]  next_ptr;
    pick_t             pick_idle;
    pick_t             pick_rel;

    assign next_ptr  = sel_q + SEL_W'(1);
    assign timeout   = (HOLD_MAX != 0) && (hold_cnt_q == HC_W'(HOLD_MAX));
    assign pick_idle = rr_pick(req, rr_ptr_q);
    // Re-arbitration on release searches from owner+1, so the releasing
    // owner is naturally visited last.
    assign pick_rel  = rr_pick(req, next_ptr);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        new_grant   = 1'b0;
        release_own = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_idle.found) begin
                    state_d    = BUSY;
                    gnt_d      = N_REQ'(1) << pick_idle.idx;
                    sel_d      = pick_idle.idx;
                    hold_cnt_d = HC_W'(1);
                    new_grant  = 1'b1;
                end
            end
            BUSY: begin
                release_own = done[sel_q] | ~req[sel_q] | timeout;
                if (release_own) begin
                    rr_ptr_d = next_ptr;
                    if (pick_rel.found) begin
                        gnt_d      = N_REQ'(1) << pick_rel.idx;
                        sel_d      = pick_rel.idx;
                        hold_cnt_d = HC_W'(1);
                        new_grant  = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        gnt_d      = '0;
                        hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q != '1) begin
                    // Only reachable without a timeout; saturate rather than wrap
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic [15:0] grant_count_q, grant_count_d;

    always_comb begin
        grant_count_d = grant_count_q;
        if (new_grant && (grant_count_q != 16'hFFFF)) begin
            grant_count_d = grant_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count_q <= '0;
        end else begin
            grant_count_q <= grant_count_d;
        end
    end

    assign grant_count = grant_count_q;
`endif

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y_valid = (state_q == BUSY);

    mux_4x1 #(.W(W)) u_mux (
        .sel (sel_q),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .y   (y)
    );

endmodule
